// File: rtl/rom.sv
// rom: 32-entry x 32-bit CORDIC arctangent constant table.
//   entry[i] = round(atan(2^-i) * 2^31), unsigned Q0.31 radians.
//   The output is registered, so data is valid one clock after address.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset; clears data to zero
//   address - CORDIC iteration index i, 0..31
//   data    - atan(2^-i) for the address sampled at the previous edge
module rom (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  address,
  output logic [31:0] data
);

  logic [31:0] data_d;
  logic [31:0] data_q;

  // From i = 11 up, atan(2^-i) rounds to exactly 2^-i, so each entry is a single set bit.
  always_comb begin
    data_d = '0;
    unique case (address)
      5'd0:  data_d = 32'h6487_ED51;
      5'd1:  data_d = 32'h3B58_CE0B;
      5'd2:  data_d = 32'h1F5B_75F9;
      5'd3:  data_d = 32'h0FEA_DD4F;
      5'd4:  data_d = 32'h07FD_56EE;
      5'd5:  data_d = 32'h03FF_AAB7;
      5'd6:  data_d = 32'h01FF_F555;
      5'd7:  data_d = 32'h00FF_FEAB;
      5'd8:  data_d = 32'h007F_FFD5;
      5'd9:  data_d = 32'h003F_FFFB;
      5'd10: data_d = 32'h001F_FFFF;
      5'd11: data_d = 32'h0010_0000;
      5'd12: data_d = 32'h0008_0000;
      5'd13: data_d = 32'h0004_0000;
      5'd14: data_d = 32'h0002_0000;
      5'd15: data_d = 32'h0001_0000;
      5'd16: data_d = 32'h0000_8000;
      5'd17: data_d = 32'h0000_4000;
      5'd18: data_d = 32'h0000_2000;
      5'd19: data_d = 32'h0000_1000;
      5'd20: data_d = 32'h0000_0800;
      5'd21: data_d = 32'h0000_0400;
      5'd22: data_d = 32'h0000_0200;
      5'd23: data_d = 32'h0000_0100;
      5'd24: data_d = 32'h0000_0080;
      5'd25: data_d = 32'h0000_0040;
      5'd26: data_d = 32'h0000_0020;
      5'd27: data_d = 32'h0000_0010;
      5'd28: data_d = 32'h0000_0008;
      5'd29: data_d = 32'h0000_0004;
      5'd30: data_d = 32'h0000_0002;
      5'd31: data_d = 32'h0000_0001;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: tb/tb_rom.sv
// tb_rom: self-checking bench for rom. Expected words are queued when an
// address is driven and popped/compared one edge later when data is valid.
module tb_rom;

  logic        clk;
  logic        reset;
  logic [4:0]  address;
  logic [31:0] data;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [31:0] sb_q[$];

  rom u_rom (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: arctangent constants for 0..10, exact powers of two beyond.
  function automatic logic [31:0] ref_atan(input int unsigned i);
    logic [31:0] t [0:10];
    logic [31:0] one;
    t[0]  = 32'h6487ED51; t[1]  = 32'h3B58CE0B; t[2]  = 32'h1F5B75F9;
    t[3]  = 32'h0FEADD4F; t[4]  = 32'h07FD56EE; t[5]  = 32'h03FFAAB7;
    t[6]  = 32'h01FFF555; t[7]  = 32'h00FFFEAB; t[8]  = 32'h007FFFD5;
    t[9]  = 32'h003FFFFB; t[10] = 32'h001FFFFF;
    one = 32'h1;
    if (i <= 10) return t[i];
    return one << (31 - i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected word and compare with data.
  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check(tag, data, e);
    end
  endtask

  // Drive an address at the falling edge, then check just after the next rising edge.
  task automatic apply(input int unsigned a, input string tag);
    @(negedge clk);
    address = a[4:0];
    sb_q.push_back(ref_atan(a));
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int unsigned order [4];
    n_cmp = 0;
    n_bad = 0;

    // Reset holds data at zero across clock edges.
    reset   = 1'b1;
    address = 5'd5;
    #1;
    check("reset_async", data, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(ref_atan(5));
    @(posedge clk);
    #1;
    sb_check("reset_release");

    // Full sweep with MSB and monotonicity properties.
    prev = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      apply(i, $sformatf("sweep_%0d", i));
      check($sformatf("msb_%0d", i), {31'b0, data[31]}, 32'h0);
      if (i > 0) check($sformatf("mono_%0d", i), {31'b0, (prev > data)}, 32'h1);
      check($sformatf("nonzero_%0d", i), {31'b0, (data != 32'h0)}, 32'h1);
      prev = data;
    end

    // Latency: address change between edges must not reach data early.
    apply(0, "lat_first");
    #2;
    address = 5'd1;
    #1;
    check("lat_hold", data, 32'h6487ED51);
    sb_q.push_back(ref_atan(1));
    @(posedge clk);
    #1;
    sb_check("lat_update");

    // Out-of-order addresses back to back.
    order[0] = 31; order[1] = 0; order[2] = 17; order[3] = 4;
    foreach (order[k]) apply(order[k], $sformatf("order_%0d", order[k]));

    // Asynchronous reset mid-stream.
    apply(2, "mid_pre");
    #2;
    reset = 1'b1;
    #1;
    check("mid_async_clear", data, 32'h0);
    @(posedge clk);
    #1;
    check("mid_hold", data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(ref_atan(2));
    @(posedge clk);
    #1;
    sb_check("mid_release");

    // Holding the address holds data.
    @(posedge clk);
    #1;
    check("hold_steady", data, 32'h1F5B75F9);

    check("sb_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
